control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Multi-cycle control unit that drives every select/strobe input of the datapath core (PC, InstMem, RegBank, ALU, DataMem, MuxPC).
- Decodes opcode/funct of the instruction currently out of InstMem and sequences FETCH → EXEC → [MEM | INWAIT] → COMMIT.
- Holds the PC (halt=1) except in the single COMMIT cycle, so register, memory and display writes happen exactly once per instruction.
- Also synchronises the user "enter" button for IN instructions and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter icount

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; shared with PC reset
opcode  in  6  inst[31:26]
funct  in  6  inst[5:0]
enter  in  1  asynchronous push-button, active-high
halt  out  1  1 = PC holds
sreg  out  1  RegBank write strobe
smux5  out  1  0 = write reg inst[15:11] (rd), 1 = inst[20:16] (rt)
smux16  out  2  0 = immediate, 1 = switches, 2 = PC
smux32  out  1  0 = ALU B from RegBank B, 1 = sign-extended 16-bit
smuxPC  out  3  0 = PC+1, 1 = branch if zero, 2 = branch if !zero, 3 = jump imm26, 4 = jump reg A
salu  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 nor, 9 pass B
smem  out  1  DataMem write strobe
sdisplay  out  1  display-register write strobe
smemtoreg  out  1  0 = ALU result, 1 = DataMem data
state  out  3  debug: 0 FETCH, 1 EXEC, 2 MEM, 3 INWAIT, 4 COMMIT, 5 HALT
icount  out  CNT_W  retired instructions, wraps

Behaviour:
- Decode:
  - op 0x00 R-type, funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A slt, 0x00 sll, 0x02 srl, 0x27 nor (smux5=0, smux32=0, sreg); 0x08 jr (smuxPC=4, no sreg).
  - 0x08 addi, 0x0C andi, 0x0D ori: smux5=1, smux32=1, smux16=0, sreg.
  - 0x23 lw: add, smux32=1, smemtoreg=1, smux5=1, sreg.
  - 0x2B sw: add, smux32=1, smem.
  - 0x04 beq / 0x05 bne: sub, smux32=0, smuxPC=1 / 2.
  - 0x02 j: smuxPC=3.
  - 0x3C in: smux16=1, smux32=1, salu=9, smux5=1, sreg.
  - 0x3D out: sdisplay.
  - 0x3F hlt.
  - Any other opcode or R-type funct: NOP (PC+1, no strobes).
- Decode result is registered on FETCH→EXEC. Selects (smux*, salu, smemtoreg) are driven from the registered decode and stay stable from EXEC through COMMIT. In FETCH they are 0.
- Transitions:
  - FETCH→EXEC always (InstMem has 1-cycle read latency).
  - EXEC→MEM if lw; →INWAIT if in; →HALT if hlt; else →COMMIT.
  - MEM→COMMIT.
  - INWAIT→COMMIT on synchronised enter rising edge, else stay.
  - COMMIT→FETCH.
  - HALT→HALT until reset.
- Latency:
  - 3 cycles for ALU, sw, branch, jump, out and NOP instructions.
  - 4 cycles for lw.
  - 3 + wait cycles for in.
- halt=0 and sreg/smem/sdisplay (per decode) only in COMMIT; all other states halt=1, strobes 0. smuxPC is forced to 0 outside COMMIT.
- enter: 2-flop synchroniser plus edge register. Only edges detected while state==INWAIT are consumed. Edges in any other state are discarded, not queued. A held button gives one edge.
- icount increments by 1 in every COMMIT cycle and wraps from 2^CNT_W-1 to 0. HALT does not count.
- Reset (any state, including MEM/INWAIT/COMMIT):
  - Next state FETCH; decode regs 0; icount 0; synchroniser cleared.
  - While reset=1, outputs are combinationally forced to halt=1, strobes 0, all selects 0, so no write occurs on the reset edge.

Test Plan:
- Reset 2 cycles, release, opcode=0x00 funct=0x20 → state 0,1,4,0; sreg=1, halt=0, smux5=0, salu=0 only in cycle 3; icount 0→1.
- opcode=0x23 → states 0,1,2,4; in MEM smemtoreg=1, smux32=1, sreg=0, halt=1; in COMMIT sreg=1, halt=0; icount +1.
- opcode=0x3C with enter low 10 cycles → stays INWAIT, halt=1. Raise enter (held 20 cycles) → exactly one COMMIT with smux16=1, salu=9, sreg=1. Enter pulse during FETCH of next add is ignored.
- opcode=0x04 → COMMIT with salu=1, smuxPC=1, halt=0. opcode=0x3F → HALT, halt=1 indefinitely, icount frozen; enter ignored. Reset → FETCH.
- Assert reset during MEM of lw → no sreg pulse, halt=1 on that edge, state=FETCH next cycle, icount=0.
- opcode=0x11 (undefined) → 3-cycle NOP, smuxPC=0, no strobes, icount +1. With CNT_W=4, 16 NOPs → icount wraps 15→0.

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the single-issue datapath core.
// Decodes the instruction out of InstMem, sequences FETCH -> EXEC ->
// [MEM | INWAIT] -> COMMIT, and drives every datapath select and strobe.
// The PC only advances in COMMIT, so every write happens once per instruction.
module control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             enter,
  output logic             halt,
  output logic             sreg,
  output logic             smux5,
  output logic [1:0]       smux16,
  output logic             smux32,
  output logic [2:0]       smuxPC,
  output logic [3:0]       salu,
  output logic             smem,
  output logic             sdisplay,
  output logic             smemtoreg,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_INWAIT = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_NOR   = 4'd8,
    ALU_PASSB = 4'd9
  } alu_e;

  typedef enum logic [2:0] {
    PC_NEXT = 3'd0,
    PC_BZ   = 3'd1,
    PC_BNZ  = 3'd2,
    PC_JIMM = 3'd3,
    PC_JREG = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    W16_IMM = 2'd0,
    W16_SW  = 2'd1,
    W16_PC  = 2'd2
  } w16_sel_e;

  // Everything the sequencer needs to know about one instruction.
  typedef struct packed {
    logic     sreg;
    logic     smem;
    logic     sdisplay;
    logic     smux5;
    w16_sel_e smux16;
    logic     smux32;
    pc_sel_e  smuxpc;
    alu_e     salu;
    logic     smemtoreg;
    logic     is_lw;
    logic     is_in;
    logic     is_hlt;
  } dec_t;

  state_e     state_q, state_d;
  dec_t       dec_c, dec_q;
  logic       r_alu;
  logic       enter_meta_q, enter_sync_q, enter_prev_q;
  logic       enter_edge;
  logic [CNT_W-1:0] icount_q;

  // Combinational decode of the instruction currently out of InstMem.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    dec_c = '0;
    r_alu = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_c.salu = ALU_ADD; r_alu = 1'b1; end
          6'h22: begin dec_c.salu = ALU_SUB; r_alu = 1'b1; end
          6'h24: begin dec_c.salu = ALU_AND; r_alu = 1'b1; end
          6'h25: begin dec_c.salu = ALU_OR;  r_alu = 1'b1; end
          6'h26: begin dec_c.salu = ALU_XOR; r_alu = 1'b1; end
          6'h2A: begin dec_c.salu = ALU_SLT; r_alu = 1'b1; end
          6'h00: begin dec_c.salu = ALU_SLL; r_alu = 1'b1; end
          6'h02: begin dec_c.salu = ALU_SRL; r_alu = 1'b1; end
          6'h27: begin dec_c.salu = ALU_NOR; r_alu = 1'b1; end
          6'h08: dec_c.smuxpc = PC_JREG;
          default: ;
        endcase
        // R-type ALU ops write rd with RegBank B as the second operand.
        dec_c.sreg = r_alu;
      end
      6'h08, 6'h0C, 6'h0D: begin
        dec_c.salu   = (opcode == 6'h08) ? ALU_ADD :
                       (opcode == 6'h0C) ? ALU_AND : ALU_OR;
        dec_c.smux5  = 1'b1;
        dec_c.smux32 = 1'b1;
        dec_c.smux16 = W16_IMM;
        dec_c.sreg   = 1'b1;
      end
      6'h23: begin
        dec_c.salu      = ALU_ADD;
        dec_c.smux32    = 1'b1;
        dec_c.smemtoreg = 1'b1;
        dec_c.smux5     = 1'b1;
        dec_c.sreg      = 1'b1;
        dec_c.is_lw     = 1'b1;
      end
      6'h2B: begin
        dec_c.salu   = ALU_ADD;
        dec_c.smux32 = 1'b1;
        dec_c.smem   = 1'b1;
      end
      6'h04: begin dec_c.salu = ALU_SUB; dec_c.smuxpc = PC_BZ;  end
      6'h05: begin dec_c.salu = ALU_SUB; dec_c.smuxpc = PC_BNZ; end
      6'h02: dec_c.smuxpc = PC_JIMM;
      6'h3C: begin
        dec_c.smux16 = W16_SW;
        dec_c.smux32 = 1'b1;
        dec_c.salu   = ALU_PASSB;
        dec_c.smux5  = 1'b1;
        dec_c.sreg   = 1'b1;
        dec_c.is_in  = 1'b1;
      end
      6'h3D: dec_c.sdisplay = 1'b1;
      6'h3F: dec_c.is_hlt = 1'b1;
      default: ;
    endcase
  end

  // Decode register: captured on the FETCH -> EXEC edge, held until the next FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q <= '0;
    end else if (state_q == S_FETCH) begin
      dec_q <= dec_c;
    end
  end

  // Enter button: two-flop synchroniser plus previous-value register for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_meta_q <= 1'b0;
      enter_sync_q <= 1'b0;
      enter_prev_q <= 1'b0;
    end else begin
      enter_meta_q <= enter;
      enter_sync_q <= enter_meta_q;
      enter_prev_q <= enter_sync_q;
    end
  end

  // One-cycle pulse per press; only INWAIT looks at it, so other edges are dropped.
  assign enter_edge = enter_sync_q & ~enter_prev_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of block ordering.
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_EXEC;
      S_EXEC: begin
        if (dec_q.is_lw)       state_d = S_MEM;
        else if (dec_q.is_in)  state_d = S_INWAIT;
        else if (dec_q.is_hlt) state_d = S_HALT;
        else                   state_d = S_COMMIT;
      end
      S_MEM:    state_d = S_COMMIT;
      S_INWAIT: if (enter_edge) state_d = S_COMMIT;
      S_COMMIT: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Retired-instruction counter: one count per COMMIT cycle, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      icount_q <= '0;
    end else if (state_q == S_COMMIT) begin
      icount_q <= icount_q + CNT_W'(1);
    end
  end

  // Datapath controls: selects from EXEC to COMMIT, strobes and PC release
  // only in COMMIT, everything quiet while reset is high.
  always_comb begin
    halt      = 1'b1;
    sreg      = 1'b0;
    smem      = 1'b0;
    sdisplay  = 1'b0;
    smux5     = 1'b0;
    smux16    = 2'd0;
    smux32    = 1'b0;
    smuxPC    = 3'd0;
    salu      = 4'd0;
    smemtoreg = 1'b0;
    if (!reset) begin
      if (state_q inside {S_EXEC, S_MEM, S_INWAIT, S_COMMIT}) begin
        smux5     = dec_q.smux5;
        smux16    = dec_q.smux16;
        smux32    = dec_q.smux32;
        salu      = dec_q.salu;
        smemtoreg = dec_q.smemtoreg;
      end
      if (state_q == S_COMMIT) begin
        halt     = 1'b0;
        smuxPC   = dec_q.smuxpc;
        sreg     = dec_q.sreg;
        smem     = dec_q.smem;
        sdisplay = dec_q.sdisplay;
      end
    end
  end

  assign state  = state_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: expected per-cycle outputs are queued
// as each instruction is issued and compared cycle by cycle on the falling edge.
module tb_control_fsm;

  localparam int CNT_W = 4;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_EXEC   = 3'd1;
  localparam logic [2:0] ST_MEM    = 3'd2;
  localparam logic [2:0] ST_INWAIT = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             enter;
  logic             halt, sreg, smux5, smux32, smem, sdisplay, smemtoreg;
  logic [1:0]       smux16;
  logic [2:0]       smuxPC;
  logic [3:0]       salu;
  logic [2:0]       state;
  logic [CNT_W-1:0] icount;

  control_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .enter     (enter),
    .halt      (halt),
    .sreg      (sreg),
    .smux5     (smux5),
    .smux16    (smux16),
    .smux32    (smux32),
    .smuxPC    (smuxPC),
    .salu      (salu),
    .smem      (smem),
    .sdisplay  (sdisplay),
    .smemtoreg (smemtoreg),
    .state     (state),
    .icount    (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       halt;
    logic       sreg;
    logic       smux5;
    logic [1:0] smux16;
    logic       smux32;
    logic [2:0] smuxpc;
    logic [3:0] salu;
    logic       smem;
    logic       sdisplay;
    logic       smemtoreg;
  } outs_t;

  typedef struct packed {
    logic [2:0]       st;
    outs_t            o;
    logic [CNT_W-1:0] ic;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic [CNT_W-1:0] ic;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Instruction description: the selects/strobes it should produce when active.
  function automatic outs_t dsel(input logic [3:0] alu, input logic m5, input logic [1:0] m16,
                                 input logic m32, input logic [2:0] mpc, input logic m2r,
                                 input logic wr, input logic mw, input logic dw);
    outs_t o;
    o.halt = 1'b0; o.salu = alu; o.smux5 = m5; o.smux16 = m16; o.smux32 = m32;
    o.smuxpc = mpc; o.smemtoreg = m2r; o.sreg = wr; o.smem = mw; o.sdisplay = dw;
    return o;
  endfunction

  // Queue n expected cycles in state st; forced=1 models reset held high.
  task automatic push(input string tag, input logic [2:0] st, input outs_t d,
                      input logic [CNT_W-1:0] icv, input int n, input bit forced);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.st = st;
      e.ic = icv;
      e.o = '0;
      e.o.halt = 1'b1;
      if (!forced) begin
        if (st == ST_EXEC || st == ST_MEM || st == ST_INWAIT || st == ST_COMMIT) begin
          e.o.smux5 = d.smux5; e.o.smux16 = d.smux16; e.o.smux32 = d.smux32;
          e.o.salu = d.salu; e.o.smemtoreg = d.smemtoreg;
        end
        if (st == ST_COMMIT) begin
          e.o.halt = 1'b0; e.o.smuxpc = d.smuxpc;
          e.o.sreg = d.sreg; e.o.smem = d.smem; e.o.sdisplay = d.sdisplay;
        end
      end
      sb_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  // Pop one expectation per clock and compare it mid-cycle.
  task automatic drain();
    exp_t  e;
    string t;
    outs_t obs;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      obs.halt = halt; obs.sreg = sreg; obs.smux5 = smux5; obs.smux16 = smux16;
      obs.smux32 = smux32; obs.smuxpc = smuxPC; obs.salu = salu; obs.smem = smem;
      obs.sdisplay = sdisplay; obs.smemtoreg = smemtoreg;
      check({t, "/state"},  32'(state),  32'(e.st));
      check({t, "/icount"}, 32'(icount), 32'(e.ic));
      check({t, "/outs"},   32'(obs),    32'(e.o));
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one instruction without wait states and check every cycle of it.
  task automatic inst(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input outs_t d, input bit is_mem);
    opcode = op;
    funct  = fn;
    push(tag, ST_FETCH, d, ic, 1, 0);
    push(tag, ST_EXEC,  d, ic, 1, 0);
    if (is_mem) push(tag, ST_MEM, d, ic, 1, 0);
    push(tag, ST_COMMIT, d, ic, 1, 0);
    drain();
    ic = ic + CNT_W'(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t d_nop, d_add, d_lw, d_sw, d_in, d_beq, d_bne, d_j, d_jr, d_out, d_r;
    logic [5:0] fn_tab [9];
    logic [3:0] alu_tab[9];

    d_nop = dsel(4'd0, 0, 2'd0, 0, 3'd0, 0, 0, 0, 0);
    d_add = dsel(4'd0, 0, 2'd0, 0, 3'd0, 0, 1, 0, 0);
    d_lw  = dsel(4'd0, 1, 2'd0, 1, 3'd0, 1, 1, 0, 0);
    d_sw  = dsel(4'd0, 0, 2'd0, 1, 3'd0, 0, 0, 1, 0);
    d_in  = dsel(4'd9, 1, 2'd1, 1, 3'd0, 0, 1, 0, 0);
    d_beq = dsel(4'd1, 0, 2'd0, 0, 3'd1, 0, 0, 0, 0);
    d_bne = dsel(4'd1, 0, 2'd0, 0, 3'd2, 0, 0, 0, 0);
    d_j   = dsel(4'd0, 0, 2'd0, 0, 3'd3, 0, 0, 0, 0);
    d_jr  = dsel(4'd0, 0, 2'd0, 0, 3'd4, 0, 0, 0, 0);
    d_out = dsel(4'd0, 0, 2'd0, 0, 3'd0, 0, 0, 0, 1);

    fn_tab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h27};
    alu_tab = '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,  4'd8};

    reset = 1'b1; enter = 1'b0; opcode = 6'h00; funct = 6'h00; ic = '0;
    @(posedge clk);
    #1;
    push("reset", ST_FETCH, d_nop, '0, 2, 1);
    drain();
    reset = 1'b0;

    // Basic R-type add, then lw with its extra MEM cycle.
    inst("add", 6'h00, 6'h20, d_add, 0);
    inst("lw",  6'h23, 6'h00, d_lw,  1);

    // IN: waits for the button, one commit per press even when held.
    opcode = 6'h3C; funct = 6'h00;
    push("in_wait", ST_FETCH,  d_in, ic, 1, 0);
    push("in_wait", ST_EXEC,   d_in, ic, 1, 0);
    push("in_wait", ST_INWAIT, d_in, ic, 10, 0);
    drain();
    enter = 1'b1;
    push("in_press", ST_INWAIT, d_in, ic, 3, 0);
    push("in_press", ST_COMMIT, d_in, ic, 1, 0);
    drain();
    ic = ic + CNT_W'(1);
    push("in_held", ST_FETCH,  d_in, ic, 1, 0);
    push("in_held", ST_EXEC,   d_in, ic, 1, 0);
    push("in_held", ST_INWAIT, d_in, ic, 14, 0);
    drain();
    enter = 1'b0;
    push("in_release", ST_INWAIT, d_in, ic, 3, 0);
    drain();
    enter = 1'b1;
    push("in_press2", ST_INWAIT, d_in, ic, 3, 0);
    push("in_press2", ST_COMMIT, d_in, ic, 1, 0);
    drain();
    ic = ic + CNT_W'(1);
    enter = 1'b0;
    inst("add_quiet", 6'h00, 6'h20, d_add, 0);

    // Pulse during FETCH of an add: must be dropped, not held for the next IN.
    opcode = 6'h00; funct = 6'h20; enter = 1'b1;
    push("add_pulse", ST_FETCH, d_add, ic, 1, 0);
    drain();
    enter = 1'b0;
    push("add_pulse", ST_EXEC,   d_add, ic, 1, 0);
    push("add_pulse", ST_COMMIT, d_add, ic, 1, 0);
    drain();
    ic = ic + CNT_W'(1);
    opcode = 6'h3C; funct = 6'h00;
    push("in_noqueue", ST_FETCH,  d_in, ic, 1, 0);
    push("in_noqueue", ST_EXEC,   d_in, ic, 1, 0);
    push("in_noqueue", ST_INWAIT, d_in, ic, 6, 0);
    drain();
    enter = 1'b1;
    push("in_press3", ST_INWAIT, d_in, ic, 3, 0);
    push("in_press3", ST_COMMIT, d_in, ic, 1, 0);
    drain();
    ic = ic + CNT_W'(1);
    enter = 1'b0;

    // Control flow, stores, display and the rest of the ALU decode.
    inst("beq",  6'h04, 6'h00, d_beq, 0);
    inst("bne",  6'h05, 6'h00, d_bne, 0);
    inst("j",    6'h02, 6'h00, d_j,   0);
    inst("jr",   6'h00, 6'h08, d_jr,  0);
    inst("sw",   6'h2B, 6'h00, d_sw,  0);
    inst("out",  6'h3D, 6'h00, d_out, 0);
    for (int i = 0; i < 9; i++) begin
      d_r = dsel(alu_tab[i], 0, 2'd0, 0, 3'd0, 0, 1, 0, 0);
      inst("rtype", 6'h00, fn_tab[i], d_r, 0);
    end
    inst("addi", 6'h08, 6'h00, dsel(4'd0, 1, 2'd0, 1, 3'd0, 0, 1, 0, 0), 0);
    inst("andi", 6'h0C, 6'h00, dsel(4'd2, 1, 2'd0, 1, 3'd0, 0, 1, 0, 0), 0);
    inst("ori",  6'h0D, 6'h00, dsel(4'd3, 1, 2'd0, 1, 3'd0, 0, 1, 0, 0), 0);
    inst("undef_op",    6'h11, 6'h00, d_nop, 0);
    inst("undef_funct", 6'h00, 6'h01, d_nop, 0);

    // HLT: stays halted, counter frozen, enter ignored, until reset.
    opcode = 6'h3F; funct = 6'h00;
    push("hlt", ST_FETCH, d_nop, ic, 1, 0);
    push("hlt", ST_EXEC,  d_nop, ic, 1, 0);
    push("hlt", ST_HALT,  d_nop, ic, 4, 0);
    drain();
    enter = 1'b1;
    push("hlt_enter", ST_HALT, d_nop, ic, 4, 0);
    drain();
    enter = 1'b0;
    push("hlt_idle", ST_HALT, d_nop, ic, 3, 0);
    drain();
    reset = 1'b1;
    push("hlt_reset", ST_HALT, d_nop, ic, 1, 1);
    drain();
    reset = 1'b0;
    ic = '0;

    // Reset during MEM of lw: no write strobe on that edge, counter cleared.
    inst("add_pre", 6'h00, 6'h20, d_add, 0);
    opcode = 6'h23; funct = 6'h00;
    push("lw_rst", ST_FETCH, d_lw, ic, 1, 0);
    push("lw_rst", ST_EXEC,  d_lw, ic, 1, 0);
    drain();
    reset = 1'b1;
    push("lw_rst_mem", ST_MEM, d_lw, ic, 1, 1);
    drain();
    reset = 1'b0;
    ic = '0;

    // Reset during COMMIT of add: strobe suppressed, no count.
    inst("add_pre2", 6'h00, 6'h20, d_add, 0);
    opcode = 6'h00; funct = 6'h20;
    push("add_rst", ST_FETCH, d_add, ic, 1, 0);
    push("add_rst", ST_EXEC,  d_add, ic, 1, 0);
    drain();
    reset = 1'b1;
    push("add_rst_commit", ST_COMMIT, d_add, ic, 1, 1);
    drain();
    reset = 1'b0;
    ic = '0;

    // 16 NOPs from zero: counter passes 15 and wraps back to 0.
    for (int i = 0; i < 16; i++) begin
      inst("nop_wrap", 6'h11, 6'h00, d_nop, 0);
    end
    inst("after_wrap", 6'h00, 6'h20, d_add, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
